// File: rtl/commit_buffer.sv
// ============================================================================
// Module      : commit_buffer
// Description : Commit-trace FIFO with back-pressure and an N-step run budget.
//               Optional same-cycle bypass when empty: COMMIT_BUF_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_buffer #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 8,
    parameter int SLACK = 2,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_i_valid,
    input  logic [ILEN-1:0]          commit_i_instr,
    input  logic [XLEN-1:0]          commit_i_pc,
    input  logic [XLEN-1:0]          commit_i_pre_pc,
    input  logic                     run_i_load,
    input  logic [CNT_W-1:0]         run_i_steps,
    input  logic                     run_i_free,
    input  logic                     drain_i_ready,
    output logic                     drain_o_valid,
    output logic [ILEN-1:0]          drain_o_instr,
    output logic [XLEN-1:0]          drain_o_pc,
    output logic [XLEN-1:0]          drain_o_pre_pc,
    output logic                     ctrl_o_stall,
    output logic [$clog2(DEPTH):0]   buf_o_count,
    output logic                     run_o_done,
    output logic                     status_o_overflow
);

    localparam int                c_PTR_W    = $clog2(DEPTH);
    localparam int                c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_STALL_AT = c_CNT_W'(DEPTH - SLACK);

    logic [ILEN-1:0]    r_memInstr [DEPTH];
    logic [XLEN-1:0]    r_memPc    [DEPTH];
    logic [XLEN-1:0]    r_memPrePc [DEPTH];

    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_headValid;
    logic [ILEN-1:0]    r_headInstr;
    logic [XLEN-1:0]    r_headPc;
    logic [XLEN-1:0]    r_headPrePc;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_done;
    logic               r_overflow;

    logic               w_bypass;
    logic               w_pop;
    logic               w_push;
    logic               w_accept;
    logic               w_drop;
    logic [c_PTR_W-1:0] w_nextRd;
    logic [c_CNT_W-1:0] w_nextCount;
    logic               w_fwd;

`ifdef COMMIT_BUF_BYPASS_EN
    // Empty buffer and a ready harness: hand the commit straight through.
    assign w_bypass       = (r_count == '0) && commit_i_valid && drain_i_ready;
    assign drain_o_valid  = r_headValid | w_bypass;
    assign drain_o_instr  = w_bypass ? commit_i_instr  : r_headInstr;
    assign drain_o_pc     = w_bypass ? commit_i_pc     : r_headPc;
    assign drain_o_pre_pc = w_bypass ? commit_i_pre_pc : r_headPrePc;
`else
    assign w_bypass       = 1'b0;
    assign drain_o_valid  = r_headValid;
    assign drain_o_instr  = r_headInstr;
    assign drain_o_pc     = r_headPc;
    assign drain_o_pre_pc = r_headPrePc;
`endif

    assign w_pop    = r_headValid && drain_i_ready;
    assign w_push   = commit_i_valid && !w_bypass && ((r_count != c_FULL) || w_pop);
    assign w_drop   = commit_i_valid && !w_bypass && (r_count == c_FULL) && !w_pop;
    assign w_accept = w_push || w_bypass;

    always_comb begin
        w_nextRd    = w_pop ? (r_rdPtr + c_PTR_W'(1)) : r_rdPtr;
        w_nextCount = r_count;
        if (w_push && !w_pop) begin
            w_nextCount = r_count + c_CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_nextCount = r_count - c_CNT_W'(1);
        end
        // The slot about to become head is being written this cycle.
        w_fwd = w_push && (r_wrPtr == w_nextRd);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memInstr[r_wrPtr] <= commit_i_instr;
            r_memPc[r_wrPtr]    <= commit_i_pc;
            r_memPrePc[r_wrPtr] <= commit_i_pre_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_headValid <= 1'b0;
            r_headInstr <= '0;
            r_headPc    <= '0;
            r_headPrePc <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            r_rdPtr     <= w_nextRd;
            r_count     <= w_nextCount;
            r_headValid <= (w_nextCount != '0);
            if (w_nextCount != '0) begin
                r_headInstr <= w_fwd ? commit_i_instr  : r_memInstr[w_nextRd];
                r_headPc    <= w_fwd ? commit_i_pc     : r_memPc[w_nextRd];
                r_headPrePc <= w_fwd ? commit_i_pre_pc : r_memPrePc[w_nextRd];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Step budget: a load overrides any decrement in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else if (run_i_load) begin
            r_remaining <= run_i_steps;
            r_done      <= (run_i_steps == '0);
        end else if (w_accept && !run_i_free && (r_remaining != '0)) begin
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign ctrl_o_stall      = (r_count >= c_STALL_AT) || (!run_i_free && (r_remaining == '0));
    assign buf_o_count       = r_count;
    assign run_o_done        = r_done;
    assign status_o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_commit_buffer.sv
// ============================================================================
// Module      : tb_commit_buffer
// Description : Self-checking bench for commit_buffer (vectors, sequences,
//               randomized traffic against a queue-based reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_buffer;

    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 8;
    localparam int SLACK = 2;
    localparam int CNT_W = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             commit_i_valid;
    logic [ILEN-1:0]  commit_i_instr;
    logic [XLEN-1:0]  commit_i_pc;
    logic [XLEN-1:0]  commit_i_pre_pc;
    logic             run_i_load;
    logic [CNT_W-1:0] run_i_steps;
    logic             run_i_free;
    logic             drain_i_ready;
    logic             drain_o_valid;
    logic [ILEN-1:0]  drain_o_instr;
    logic [XLEN-1:0]  drain_o_pc;
    logic [XLEN-1:0]  drain_o_pre_pc;
    logic             ctrl_o_stall;
    logic [CW-1:0]    buf_o_count;
    logic             run_o_done;
    logic             status_o_overflow;

    commit_buffer #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .SLACK(SLACK), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .commit_i_valid(commit_i_valid), .commit_i_instr(commit_i_instr),
        .commit_i_pc(commit_i_pc), .commit_i_pre_pc(commit_i_pre_pc),
        .run_i_load(run_i_load), .run_i_steps(run_i_steps), .run_i_free(run_i_free),
        .drain_i_ready(drain_i_ready), .drain_o_valid(drain_o_valid),
        .drain_o_instr(drain_o_instr), .drain_o_pc(drain_o_pc),
        .drain_o_pre_pc(drain_o_pre_pc), .ctrl_o_stall(ctrl_o_stall),
        .buf_o_count(buf_o_count), .run_o_done(run_o_done),
        .status_o_overflow(status_o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] prePc;
        logic [ILEN-1:0] instr;
    } ent_t;

    // Reference model: a plain queue of buffered commits plus budget counters.
    ent_t        q[$];
    int unsigned mRem;
    bit          mDone;
    bit          mOvf;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bypassNow();
`ifdef COMMIT_BUF_BYPASS_EN
        return (q.size() == 0) && commit_i_valid && drain_i_ready;
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelEdge();
        bit   pop;
        bit   bp;
        bit   push;
        ent_t e;
        if (rst) begin
            q.delete();
            mRem  = 0;
            mDone = 0;
            mOvf  = 0;
            return;
        end
        pop  = (q.size() > 0) && drain_i_ready;
        bp   = bypassNow();
        push = commit_i_valid && !bp && ((q.size() < DEPTH) || pop);
        if (commit_i_valid && !bp && q.size() == DEPTH && !pop) mOvf = 1;
        if (pop) void'(q.pop_front());
        if (push) begin
            e.pc    = commit_i_pc;
            e.prePc = commit_i_pre_pc;
            e.instr = commit_i_instr;
            q.push_back(e);
        end
        if (run_i_load) begin
            mRem  = run_i_steps;
            mDone = (run_i_steps == 0);
        end else if ((push || bp) && !run_i_free && mRem > 0) begin
            mRem--;
            if (mRem == 0) mDone = 1;
        end
    endtask

    task automatic checkModel();
        bit bp;
        bp = bypassNow();
        chk("count", buf_o_count, q.size());
        chk("valid", drain_o_valid, (q.size() > 0) || bp);
        if (bp) begin
            chk("bypassPc", drain_o_pc, commit_i_pc);
            chk("bypassInstr", drain_o_instr, commit_i_instr);
        end else if (q.size() > 0) begin
            chk("headPc", drain_o_pc, q[0].pc);
            chk("headPrePc", drain_o_pre_pc, q[0].prePc);
            chk("headInstr", drain_o_instr, q[0].instr);
        end
        chk("stall", ctrl_o_stall, (q.size() >= DEPTH - SLACK) || (!run_i_free && mRem == 0));
        chk("done", run_o_done, mDone);
        chk("overflow", status_o_overflow, mOvf);
    endtask

    task automatic step(input bit v, input logic [63:0] pc, input bit rdy, input bit ld,
                        input int unsigned steps, input bit fr, input bit r);
        logic [63:0] p;
        p               = pc;
        rst             = r;
        commit_i_valid  = v;
        commit_i_pc     = p;
        commit_i_pre_pc = p + 64'd4;
        commit_i_instr  = p[31:0] ^ 32'h0000_0013;
        run_i_load      = ld;
        run_i_steps     = steps;
        run_i_free      = fr;
        drain_i_ready   = rdy;
        @(posedge clk);
        modelEdge();
        #1;
        checkModel();
    endtask

    task automatic doReset(input bit fr);
        step(0, 64'd0, 0, 0, 0, fr, 1);
        step(0, 64'd0, 0, 0, 0, fr, 1);
    endtask

    typedef struct {
        bit          v;
        bit          rdy;
        bit          ld;
        int unsigned steps;
        bit          fr;
        int          cnt;
        bit          stall;
        bit          done;
        bit          ovf;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic [63:0] pcs[3];
        vecs = '{
            '{1,0,0,0,1, 1,0,0,0}, '{1,0,0,0,1, 2,0,0,0}, '{1,0,0,0,1, 3,0,0,0},
            '{1,0,0,0,1, 4,0,0,0}, '{1,0,0,0,1, 5,0,0,0}, '{1,0,0,0,1, 6,1,0,0},
            '{1,0,0,0,1, 7,1,0,0}, '{1,0,0,0,1, 8,1,0,0}, '{1,0,0,0,1, 8,1,0,1},
            '{1,1,0,0,1, 8,1,0,1}, '{0,1,0,0,1, 7,1,0,1}, '{0,1,1,2,0, 6,1,0,1},
            '{0,1,0,0,0, 5,0,0,1}, '{1,0,0,0,0, 6,1,0,1}, '{0,1,0,0,0, 5,0,0,1},
            '{1,1,0,0,0, 5,1,1,1}, '{0,1,1,0,0, 4,1,1,1}, '{1,0,1,3,0, 5,0,0,1}
        };

        // Reset state
        doReset(0);
        chk("rstValid", drain_o_valid, 0);
        chk("rstPc", drain_o_pc, 0);
        chk("rstInstr", drain_o_instr, 0);
        chk("rstStall", ctrl_o_stall, 1);
        chk("rstCount", buf_o_count, 0);

        // Vector table: fill, overflow, full push+pop, budget load/exhaust/reload
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].v, 64'h8000_1000 + 64'(4 * i), vecs[i].rdy, vecs[i].ld,
                 vecs[i].steps, vecs[i].fr, 0);
            chk($sformatf("vec%0d.count", i), buf_o_count, vecs[i].cnt);
            chk($sformatf("vec%0d.stall", i), ctrl_o_stall, vecs[i].stall);
            chk($sformatf("vec%0d.done", i), run_o_done, vecs[i].done);
            chk($sformatf("vec%0d.ovf", i), status_o_overflow, vecs[i].ovf);
        end

        // Streaming three commits with the harness always ready
        doReset(1);
        pcs = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
        for (int i = 0; i < 3; i++) begin
            step(1, pcs[i], 1, 0, 0, 1, 0);
            chk($sformatf("stream%0d.pc", i), drain_o_pc, pcs[i]);
            chk($sformatf("stream%0d.stall", i), ctrl_o_stall, 0);
        end
        step(0, 64'd0, 1, 0, 0, 1, 0);

        // Full buffer, simultaneous push+pop across pointer wrap
        doReset(1);
        for (int i = 0; i < DEPTH; i++) step(1, 64'h8000_2000 + 64'(4 * i), 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 64'h8000_3000 + 64'(4 * i), 1, 0, 0, 1, 0);
            chk($sformatf("fullPP%0d.count", i), buf_o_count, DEPTH);
            chk($sformatf("fullPP%0d.ovf", i), status_o_overflow, 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 64'd0, 1, 0, 0, 1, 0);

        // Budget of 5 with continuous commits
        doReset(0);
        step(0, 64'd0, 1, 1, 5, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1, 64'h8000_4000 + 64'(4 * i), 1, 0, 0, 0, 0);
            chk($sformatf("budget%0d.done", i), run_o_done, (i >= 4));
        end
        chk("budgetStall", ctrl_o_stall, 1);
        step(0, 64'd0, 1, 1, 2, 0, 0);
        chk("reloadDone", run_o_done, 0);
        chk("reloadStall", ctrl_o_stall, 0);

        // Load coinciding with a commit at remaining == 1
        doReset(0);
        step(0, 64'd0, 0, 1, 1, 0, 0);
        step(1, 64'h8000_5000, 0, 1, 3, 0, 0);
        chk("loadWinsDone", run_o_done, 0);
        step(1, 64'h8000_5004, 0, 0, 0, 0, 0);
        step(1, 64'h8000_5008, 0, 0, 0, 0, 0);
        chk("loadWins2", run_o_done, 0);
        step(1, 64'h8000_500c, 0, 0, 0, 0, 0);
        chk("loadWins3", run_o_done, 1);

`ifdef COMMIT_BUF_BYPASS_EN
        // Same-cycle bypass on an empty buffer
        doReset(1);
        commit_i_valid  = 1;
        commit_i_pc     = 64'h8000_0010;
        commit_i_pre_pc = 64'h8000_0014;
        commit_i_instr  = 32'h0000_0013;
        drain_i_ready   = 1;
        #1;
        chk("bypassValid", drain_o_valid, 1);
        chk("bypassPcNow", drain_o_pc, 64'h8000_0010);
        @(posedge clk);
        modelEdge();
        #1;
        checkModel();
        chk("bypassCount", buf_o_count, 0);
`endif

        // Randomized traffic against the reference model
        doReset(1);
        begin
            bit fr = 1;
            for (int i = 0; i < 3000; i++) begin
                bit ld;
                if ($urandom_range(0, 49) == 0) fr = ~fr;
                ld = !fr && ($urandom_range(0, 19) == 0);
                step($urandom_range(0, 9) < 6, {$urandom, $urandom} & ~64'h3,
                     $urandom_range(0, 1), ld, $urandom_range(0, 6), fr,
                     $urandom_range(0, 99) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
